// File: rtl/sm_input_debounce.sv
// Per-channel input debouncer: two-flop synchronizer, stability counter and
// registered rise/fall/changed pulses for board keys and switches.
module sm_input_debounce #(
  parameter int               WIDTH           = 12,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    PENDING
  } state_t;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt   [WIDTH];
  state_t           state [WIDTH];
  logic [WIDTH-1:0] qualify;

  // A channel qualifies on the edge where its disagreement has lasted long enough.
  always_comb begin
    qualify = '0;
    for (int i = 0; i < WIDTH; i++) begin
      qualify[i] = (state[i] == PENDING) && (sync2[i] != level[i]) && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= RESET_LEVEL;
      sync2   <= RESET_LEVEL;
      level   <= RESET_LEVEL;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i]   <= '0;
        state[i] <= STABLE;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      changed <= |qualify;
      for (int i = 0; i < WIDTH; i++) begin
        rise[i] <= qualify[i] & sync2[i];
        fall[i] <= qualify[i] & ~sync2[i];
        case (state[i])
          STABLE: begin
            if (sync2[i] != level[i]) begin
              state[i] <= PENDING;
              cnt[i]   <= CW'(1);
            end else begin
              cnt[i] <= '0;
            end
          end
          PENDING: begin
            if (sync2[i] == level[i]) begin
              state[i] <= STABLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == LAST) begin
              level[i] <= sync2[i];
              state[i] <= STABLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: begin
            state[i] <= STABLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sm_input_debounce.md
SM_INPUT_DEBOUNCE -- requirements
Module: sm_input_debounce

Interface
REQ-001 Parameter WIDTH, default 12, number of independent input channels (KEY[1:0] plus SW[9:0] on the board).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable clk cycles required to accept a new level; legal range 2..2^24.
REQ-003 Parameter RESET_LEVEL, default {WIDTH{1'b1}}, per-channel debounced level loaded at reset (keys idle high).
REQ-004 clk  input  1  the single clock of the block; every register updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 raw  input  WIDTH  asynchronous board inputs (keys, switches).
REQ-007 level  output  WIDTH  debounced, clk-synchronous level per channel.
REQ-008 rise  output  WIDTH  one-cycle pulse per channel when level goes 0->1.
REQ-009 fall  output  WIDTH  one-cycle pulse per channel when level goes 1->0.
REQ-010 changed  output  1  OR of all rise and fall bits, same cycle.

Function
REQ-011 Each channel SHALL be processed independently; no channel's state affects another.
REQ-012 Each channel SHALL pass raw through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-013 Each channel SHALL own a counter of width clog2(DEBOUNCE_CYCLES), unsigned, never wrapping.
REQ-014 States per channel: STABLE (sync2 == level, counter = 0) and PENDING (sync2 != level, counter counting).
REQ-015 STABLE -> PENDING: on the first edge where sync2 != level; counter increments 0 -> 1.
REQ-016 PENDING, sync2 != level, counter < DEBOUNCE_CYCLES-1: counter increments by 1.
REQ-017 PENDING, sync2 != level, counter == DEBOUNCE_CYCLES-1: level <= sync2, counter <= 0, the matching rise/fall bit is high for exactly the next cycle, return to STABLE.
REQ-018 PENDING, sync2 == level (glitch ends early): counter <= 0, return to STABLE, no level change, no pulse.
REQ-019 Latency: a raw change first sampled at edge E, then held stable, SHALL change level at edge E+DEBOUNCE_CYCLES+1.
REQ-020 A raw pulse lasting fewer than DEBOUNCE_CYCLES sync2 cycles SHALL never change level.
REQ-021 rise and fall for one channel SHALL never be high in the same cycle; pulses SHALL be registered outputs, high one cycle only.
REQ-022 Multiple channels qualifying on the same edge SHALL all update and pulse in that same cycle; changed asserts once.
REQ-023 level SHALL be glitch-free and change only on a clk edge.

Reset
REQ-024 When rst is high at an edge: level <= RESET_LEVEL, sync1 and sync2 <= RESET_LEVEL, all counters <= 0, rise, fall, changed <= 0.
REQ-025 rst asserted mid-PENDING SHALL abandon the pending change with no pulse; after rst release counting restarts from 0.
REQ-026 If raw differs from RESET_LEVEL after reset, the channel SHALL debounce to the raw value with full latency per REQ-019 and emit the matching pulse.
REQ-027 rst SHALL take priority over all other activity in the same cycle.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=2'b11)
REQ-028 Reset: rst high 2 cycles with raw=2'b11 -> level=2'b11, rise=fall=0, changed=0.
REQ-029 Clean press: raw[0] 1->0 held, first sampled edge E -> level[0]=0 after edge E+5, fall[0] high one cycle, changed high one cycle, level[1] unchanged.
REQ-030 Bounce: raw[0] toggles 0/1 every 2 cycles for 20 cycles then settles 0 -> no pulse during toggling; single fall[0] 5 edges after settling.
REQ-031 Simultaneous: raw 2'b11->2'b00 same edge -> fall=2'b11 same cycle, changed high one cycle; raw back to 2'b11 -> rise=2'b11.
REQ-032 Reset mid-pending: raw[1] 1->0, rst high 3 edges later -> level[1] stays 1, no fall; after rst release, fall[1] exactly 5 edges later.
REQ-033 Glitch: raw[1] low for exactly 3 sampled cycles -> level[1] stays 1, no pulse, counter back to 0.
